// File: rtl/alu_ctrl_seq_pkg.sv
// alu_ctrl_seq shared types: opcodes, T-states,
// datapath strobe bundle and opcode class record.
package alu_ctrl_seq_pkg;

  localparam int OPW_DEF = 5;
  localparam int TMO_DEF = 15;

  localparam logic [4:0] OP_ADD  = 5'b00101;
  localparam logic [4:0] OP_SUB  = 5'b00110;
  localparam logic [4:0] OP_AND  = 5'b00111;
  localparam logic [4:0] OP_OR   = 5'b01000;
  localparam logic [4:0] OP_SHR  = 5'b01001;
  localparam logic [4:0] OP_SHL  = 5'b01010;
  localparam logic [4:0] OP_ROR  = 5'b01011;
  localparam logic [4:0] OP_ROL  = 5'b01100;
  localparam logic [4:0] OP_ADDI = 5'b01101;
  localparam logic [4:0] OP_ANDI = 5'b01110;
  localparam logic [4:0] OP_ORI  = 5'b01111;
  localparam logic [4:0] OP_MUL  = 5'b10000;
  localparam logic [4:0] OP_DIV  = 5'b10001;
  localparam logic [4:0] OP_NEG  = 5'b10010;
  localparam logic [4:0] OP_NOT  = 5'b10011;
  localparam logic [4:0] OP_HALT = 5'b11011;

  typedef enum logic [2:0] {
    T0 = 3'd0,
    T1 = 3'd1,
    T2 = 3'd2,
    T3 = 3'd3,
    T4 = 3'd4,
    T5 = 3'd5,
    T6 = 3'd6
  } tstate_e;

  typedef struct packed {
    logic pc_out;
    logic mar_in;
    logic inc_pc;
    logic z_in;
    logic zlo_out;
    logic zhi_out;
    logic pc_in;
    logic mem_read;
    logic mdr_in;
    logic mdr_out;
    logic ir_in;
    logic y_in;
    logic c_out;
    logic gra;
    logic grb;
    logic grc;
    logic r_in;
    logic r_out;
    logic hi_in;
    logic lo_in;
  } strobe_t;

  typedef struct packed {
    logic supported;
    logic is_imm;
    logic is_unary;
    logic is_muldiv;
  } op_class_t;

endpackage

// File: rtl/alu_ctrl_seq_decode.sv
// alu_op_decode: classifies an opcode into
// supported / immediate / unary / mul-div.
module alu_op_decode
  import alu_ctrl_seq_pkg::*;
#(
  parameter int OPW = OPW_DEF
) (
  input  logic [OPW-1:0] op,
  output op_class_t      cls
);

  // one-hot class match on opcode ranges
  always_comb begin
    cls = '0;
    unique case (1'b1)
      (op >= OP_ADD && op <= OP_ROL): begin
        cls.supported = 1'b1;
      end
      (op >= OP_ADDI && op <= OP_ORI): begin
        cls.supported = 1'b1;
        cls.is_imm    = 1'b1;
      end
      (op == OP_MUL || op == OP_DIV): begin
        cls.supported = 1'b1;
        cls.is_muldiv = 1'b1;
      end
      (op == OP_NEG || op == OP_NOT): begin
        cls.supported = 1'b1;
        cls.is_unary  = 1'b1;
      end
      (op == OP_HALT): begin
        cls.supported = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_ctrl_seq.sv
// alu_ctrl_seq: T-state sequencer driving the
// datapath strobes, ALU opcode and sticky flags.
module alu_ctrl_seq
  import alu_ctrl_seq_pkg::*;
#(
  parameter int OPW     = OPW_DEF,
  parameter int MEM_TMO = TMO_DEF
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           run,
  input  logic [31:0]    ir,
  input  logic           mem_ready,
  output logic           pc_out,
  output logic           mar_in,
  output logic           inc_pc,
  output logic           z_in,
  output logic           zlo_out,
  output logic           zhi_out,
  output logic           pc_in,
  output logic           mem_read,
  output logic           mdr_in,
  output logic           mdr_out,
  output logic           ir_in,
  output logic           y_in,
  output logic           c_out,
  output logic           gra,
  output logic           grb,
  output logic           grc,
  output logic           r_in,
  output logic           r_out,
  output logic           hi_in,
  output logic           lo_in,
  output logic [OPW-1:0] alu_op,
  output logic           illegal,
  output logic           bus_err,
  output logic           halted
);

  tstate_e        state_q, state_d;
  logic [3:0]     tmo_q, tmo_d;
  logic [OPW-1:0] op_q, op_d;
  logic           err_q, err_d;
  logic           halt_q, halt_d;

  logic [OPW-1:0] ir_op;
  logic [OPW-1:0] dec_op;
  op_class_t      cls;
  logic           fetch_ok;
  strobe_t        s;
  logic [OPW-1:0] alu_d;
  logic           ill_d;
  logic           unused_ir;

  assign ir_op     = ir[31 -: OPW];
  assign unused_ir = ^ir[31-OPW:0];
  assign dec_op    = (state_q == T3) ? ir_op : op_q;
  assign fetch_ok  = run && !halt_q && !err_q;

  alu_op_decode #(.OPW(OPW)) u_dec (
    .op  (dec_op),
    .cls (cls)
  );

  // state, timeout counter, opcode and sticky flags
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= T0;
      tmo_q   <= '0;
      op_q    <= '0;
      err_q   <= 1'b0;
      halt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
      op_q    <= op_d;
      err_q   <= err_d;
      halt_q  <= halt_d;
    end
  end

  // next-state, counter and flag updates
  always_comb begin
    state_d = state_q;
    tmo_d   = tmo_q;
    op_d    = op_q;
    err_d   = err_q;
    halt_d  = halt_q;
    unique case (state_q)
      T0: begin
        if (fetch_ok) begin
          state_d = T1;
          tmo_d   = '0;
        end
      end
      T1: begin
        if (mem_ready) begin
          state_d = T2;
        end else if (tmo_q == 4'(MEM_TMO - 1)) begin
          err_d   = 1'b1;
          state_d = T0;
        end else begin
          tmo_d = tmo_q + 4'd1;
        end
      end
      T2: state_d = T3;
      T3: begin
        op_d = ir_op;
        if (!cls.supported) begin
          state_d = T0;
        end else if (ir_op == OP_HALT) begin
          halt_d  = 1'b1;
          state_d = T0;
        end else begin
          state_d = T4;
        end
      end
      T4: state_d = T5;
      T5: state_d = cls.is_muldiv ? T6 : T0;
      T6: state_d = T0;
      default: state_d = T0;
    endcase
  end

  // per-state strobe decode, silenced in reset
  always_comb begin
    s     = '0;
    alu_d = '0;
    ill_d = 1'b0;
    if (!reset) begin
      unique case (state_q)
        T0: begin
          if (fetch_ok) begin
            s.pc_out = 1'b1;
            s.mar_in = 1'b1;
            s.inc_pc = 1'b1;
            s.z_in   = 1'b1;
          end
        end
        T1: begin
          s.zlo_out  = 1'b1;
          s.pc_in    = 1'b1;
          s.mem_read = 1'b1;
          s.mdr_in   = mem_ready;
        end
        T2: begin
          s.mdr_out = 1'b1;
          s.ir_in   = 1'b1;
        end
        T3: begin
          if (!cls.supported) begin
            ill_d = 1'b1;
          end else if (ir_op != OP_HALT) begin
            s.grb   = 1'b1;
            s.r_out = 1'b1;
            s.y_in  = 1'b1;
          end
        end
        T4: begin
          alu_d  = op_q;
          s.z_in = 1'b1;
          if (cls.is_imm) begin
            s.c_out = 1'b1;
          end else if (cls.is_unary) begin
            s.grb   = 1'b1;
            s.r_out = 1'b1;
          end else begin
            s.grc   = 1'b1;
            s.r_out = 1'b1;
          end
        end
        T5: begin
          s.zlo_out = 1'b1;
          if (cls.is_muldiv) begin
            s.lo_in = 1'b1;
          end else begin
            s.gra  = 1'b1;
            s.r_in = 1'b1;
          end
        end
        T6: begin
          s.zhi_out = 1'b1;
          s.hi_in   = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign pc_out   = s.pc_out;
  assign mar_in   = s.mar_in;
  assign inc_pc   = s.inc_pc;
  assign z_in     = s.z_in;
  assign zlo_out  = s.zlo_out;
  assign zhi_out  = s.zhi_out;
  assign pc_in    = s.pc_in;
  assign mem_read = s.mem_read;
  assign mdr_in   = s.mdr_in;
  assign mdr_out  = s.mdr_out;
  assign ir_in    = s.ir_in;
  assign y_in     = s.y_in;
  assign c_out    = s.c_out;
  assign gra      = s.gra;
  assign grb      = s.grb;
  assign grc      = s.grc;
  assign r_in     = s.r_in;
  assign r_out    = s.r_out;
  assign hi_in    = s.hi_in;
  assign lo_in    = s.lo_in;
  assign alu_op   = alu_d;
  assign illegal  = ill_d;
  assign bus_err  = err_q;
  assign halted   = halt_q;

  // at most one source drives the shared bus
  a_one_driver : assert property (
    @(posedge clock) disable iff (reset)
    $onehot0({s.pc_out, s.zlo_out, s.zhi_out,
              s.mdr_out, s.c_out, s.r_out})
  );

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// tb_alu_ctrl_seq: table vectors, random
// instructions and corner sequences vs a model.
module tb_alu_ctrl_seq;

  typedef struct packed {
    logic pc_out, mar_in, inc_pc, z_in;
    logic zlo_out, zhi_out, pc_in, mem_read;
    logic mdr_in, mdr_out, ir_in, y_in;
    logic c_out, gra, grb, grc;
    logic r_in, r_out, hi_in, lo_in;
    logic [4:0] alu_op;
    logic illegal, bus_err, halted;
  } obs_t;

  typedef struct {
    logic [4:0] op;
    int         waits;
    int         cycles;
  } vec_t;

  logic clock = 0;
  logic reset = 1;
  logic run = 0;
  logic [31:0] ir = '0;
  logic mem_ready = 1;
  logic pc_out, mar_in, inc_pc, z_in;
  logic zlo_out, zhi_out, pc_in, mem_read;
  logic mdr_in, mdr_out, ir_in, y_in;
  logic c_out, gra, grb, grc;
  logic r_in, r_out, hi_in, lo_in;
  logic [4:0] alu_op;
  logic illegal, bus_err, halted;

  int errors = 0;
  int checks = 0;
  obs_t exp_q[$];
  logic m_err = 0;
  logic m_halted = 0;

  always #5 clock = ~clock;

  alu_ctrl_seq dut (
    .clock(clock), .reset(reset), .run(run),
    .ir(ir), .mem_ready(mem_ready),
    .pc_out(pc_out), .mar_in(mar_in),
    .inc_pc(inc_pc), .z_in(z_in),
    .zlo_out(zlo_out), .zhi_out(zhi_out),
    .pc_in(pc_in), .mem_read(mem_read),
    .mdr_in(mdr_in), .mdr_out(mdr_out),
    .ir_in(ir_in), .y_in(y_in), .c_out(c_out),
    .gra(gra), .grb(grb), .grc(grc),
    .r_in(r_in), .r_out(r_out),
    .hi_in(hi_in), .lo_in(lo_in),
    .alu_op(alu_op), .illegal(illegal),
    .bus_err(bus_err), .halted(halted)
  );

  function automatic obs_t sample();
    obs_t o;
    o = '{pc_out, mar_in, inc_pc, z_in,
          zlo_out, zhi_out, pc_in, mem_read,
          mdr_in, mdr_out, ir_in, y_in,
          c_out, gra, grb, grc,
          r_in, r_out, hi_in, lo_in,
          alu_op, illegal, bus_err, halted};
    return o;
  endfunction

  function automatic obs_t idle();
    obs_t o;
    o = '0;
    o.bus_err = m_err;
    o.halted  = m_halted;
    return o;
  endfunction

  function automatic bit legal(logic [4:0] op);
    return (op >= 5 && op <= 19) || op == 27;
  endfunction

  task automatic check(string nm, obs_t got, obs_t ex);
    checks++;
    if (got !== ex) begin
      errors++;
      $display("FAIL %s got=%h expected=%h",
               nm, got, ex);
    end
  endtask

  // expected per-cycle outputs of one instruction
  task automatic model_instr(logic [4:0] op, int waits);
    obs_t o;
    o = idle();
    o.pc_out = 1; o.mar_in = 1;
    o.inc_pc = 1; o.z_in = 1;
    exp_q.push_back(o);
    for (int i = 0; i < waits && i < 15; i++) begin
      o = idle();
      o.zlo_out = 1; o.pc_in = 1; o.mem_read = 1;
      exp_q.push_back(o);
    end
    if (waits >= 15) begin
      m_err = 1;
      return;
    end
    o = idle();
    o.zlo_out = 1; o.pc_in = 1;
    o.mem_read = 1; o.mdr_in = 1;
    exp_q.push_back(o);
    o = idle();
    o.mdr_out = 1; o.ir_in = 1;
    exp_q.push_back(o);
    o = idle();
    if (!legal(op)) o.illegal = 1;
    else if (op != 27) begin
      o.grb = 1; o.r_out = 1; o.y_in = 1;
    end
    exp_q.push_back(o);
    if (!legal(op)) return;
    if (op == 27) begin
      m_halted = 1;
      return;
    end
    o = idle();
    o.alu_op = op;
    o.z_in = 1;
    if (op >= 13 && op <= 15) o.c_out = 1;
    else if (op == 18 || op == 19) begin
      o.grb = 1; o.r_out = 1;
    end else begin
      o.grc = 1; o.r_out = 1;
    end
    exp_q.push_back(o);
    o = idle();
    o.zlo_out = 1;
    if (op == 16 || op == 17) o.lo_in = 1;
    else begin
      o.gra = 1; o.r_in = 1;
    end
    exp_q.push_back(o);
    if (op == 16 || op == 17) begin
      o = idle();
      o.zhi_out = 1; o.hi_in = 1;
      exp_q.push_back(o);
    end
  endtask

  // enters and leaves at posedge+1 with DUT in T0
  task automatic run_instr(logic [4:0] op,
                           int waits, int n);
    logic [26:0] lo;
    exp_q.delete();
    model_instr(op, waits);
    lo = 27'($urandom);
    ir = {op, lo};
    for (int k = 0; k < n; k++) begin
      mem_ready = (k >= 1 && k <= waits) ? 0 : 1;
      @(negedge clock);
      if (k < exp_q.size())
        check($sformatf("op%0d_c%0d", op, k),
              sample(), exp_q[k]);
      else begin
        checks++;
        errors++;
        $display("FAIL len op%0d cycle=%0d model=%0d",
                 op, k, exp_q.size());
      end
      @(posedge clock);
      #1;
    end
    mem_ready = 1;
  endtask

  task automatic check_idle(string nm, int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clock);
      check(nm, sample(), idle());
      @(posedge clock);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1;
    run = 0;
    repeat (2) @(posedge clock);
    #1;
    m_err = 0;
    m_halted = 0;
    @(negedge clock);
    check("reset", sample(), idle());
    reset = 0;
    @(posedge clock);
    #1;
  endtask

  vec_t tbl[11];

  initial begin
    #2000000;
    $display("FAIL watchdog time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] op;
    tbl[0]  = '{5'b00101, 0, 6};
    tbl[1]  = '{5'b10000, 0, 7};
    tbl[2]  = '{5'b01110, 0, 6};
    tbl[3]  = '{5'b10010, 0, 6};
    tbl[4]  = '{5'b00101, 3, 9};
    tbl[5]  = '{5'b11111, 0, 4};
    tbl[6]  = '{5'b10001, 1, 8};
    tbl[7]  = '{5'b10011, 0, 6};
    tbl[8]  = '{5'b01111, 2, 8};
    tbl[9]  = '{5'b00000, 0, 4};
    tbl[10] = '{5'b01100, 0, 6};

    do_reset();
    run = 1;
    foreach (tbl[i])
      run_instr(tbl[i].op, tbl[i].waits,
                tbl[i].cycles);

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0)
        op = 5'($urandom_range(0, 31));
      else
        op = 5'($urandom_range(5, 19));
      if (op == 5'd27) op = 5'd5;
      exp_q.delete();
      model_instr(op, 0);
      begin
        int w;
        int n;
        w = $urandom_range(0, 4);
        exp_q.delete();
        model_instr(op, w);
        n = exp_q.size();
        run_instr(op, w, n);
      end
      if ($urandom_range(0, 4) == 0) begin
        run = 0;
        check_idle("stall", $urandom_range(1, 3));
        run = 1;
      end
    end

    // reset landing in T4
    run_instr(5'b00101, 0, 4);
    @(negedge clock);
    check("t4_before_reset", sample(), exp_q[4]);
    reset = 1;
    @(posedge clock);
    #1;
    @(negedge clock);
    check("reset_in_t4", sample(), idle());
    reset = 0;
    run = 0;
    @(posedge clock);
    #1;
    check_idle("run0_t0", 2);

    // memory timeout
    run = 1;
    run_instr(5'b00101, 15, 16);
    check_idle("bus_err_stuck", 3);
    do_reset();

    // halt
    run = 1;
    run_instr(5'b11011, 0, 4);
    check_idle("halted_stuck", 3);
    do_reset();

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
